// File: rtl/inst_mem_resp.sv
// ---------------------------------------------------------------------------
// inst_mem_resp
//
// Instruction-memory responder for the LC3 fetch path. Fetch requests (PC)
// are accepted while fewer than MAX_OUTST fetches are in flight. Each one
// returns its instruction word LATENCY cycles later with a one-cycle
// complete_instr strobe. Completions come back in acceptance order. A
// side-band load port writes the instruction array at any time.
//
// Parameters:
//   ADDR_W     PC / load address width
//   DATA_W     instruction word width
//   DEPTH      number of words in the array (<= 2**ADDR_W)
//   LATENCY    cycles from acceptance to completion (>= 1)
//   MAX_OUTST  maximum fetches in flight (1..LATENCY)
//   TRAP_WORD  word returned for an out-of-range PC (trap build only)
//
// Ports:
//   clock           single clock, rising edge
//   reset           asynchronous, active-high
//   PC              fetch address, sampled on acceptance
//   instrmem_rd     fetch request
//   req_ready       a request can be accepted this cycle
//   instr_dout      returned word; holds its value between completions
//   complete_instr  one-cycle strobe, instr_dout valid
//   addr_err        qualifies complete_instr: the returned PC was out of range
//   load_en         array write enable
//   load_addr       array write address
//   load_data       array write data
//
// Build option:
//   INST_MEM_OOR_TRAP_EN  when defined, a PC >= DEPTH returns TRAP_WORD with
//                         addr_err=1, and a load_addr >= DEPTH is dropped.
//                         When undefined, both addresses wrap modulo DEPTH
//                         and addr_err is always 0.
// ---------------------------------------------------------------------------
module inst_mem_resp #(
  parameter int               ADDR_W    = 16,
  parameter int               DATA_W    = 16,
  parameter int               DEPTH     = 256,
  parameter int               LATENCY   = 2,
  parameter int               MAX_OUTST = 2,
  parameter logic [DATA_W-1:0] TRAP_WORD = DATA_W'(16'hF025)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PC,
  input  logic              instrmem_rd,
  output logic              req_ready,
  output logic [DATA_W-1:0] instr_dout,
  output logic              complete_instr,
  output logic              addr_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  // Parameter sanity checks, evaluated at elaboration.
  if (LATENCY < 1) begin : g_chk_latency
    $error("inst_mem_resp: LATENCY must be at least 1");
  end
  if ((MAX_OUTST < 1) || (MAX_OUTST > LATENCY)) begin : g_chk_outst
    $error("inst_mem_resp: MAX_OUTST must be in 1..LATENCY");
  end
  if ((DEPTH < 1) || ((ADDR_W < 31) && (DEPTH > (1 << ADDR_W)))) begin : g_chk_depth
    $error("inst_mem_resp: DEPTH must be in 1..2**ADDR_W");
  end

  // Address modulo DEPTH. One extra bit keeps the divisor non-zero even
  // when DEPTH equals 2**ADDR_W.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'({1'b0, a} % (ADDR_W + 1)'(DEPTH));
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic              accept;
  logic              completing;
  logic              fetch_err;
  logic              load_we;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] last_data;
  logic              last_err;
  logic              last_vin;
  logic              out_clr_reg;

  // Ready looks only at the registered count. A completion in this cycle
  // frees its slot from the next cycle on.
  assign req_ready = (count_reg < CNT_W'(MAX_OUTST));
  assign accept    = instrmem_rd & req_ready;

  assign rd_idx = wrap_idx(PC);
  assign ld_idx = wrap_idx(load_addr);

`ifdef INST_MEM_OOR_TRAP_EN
  assign fetch_err = ~in_range(PC);
  assign load_we   = load_en & in_range(load_addr);
`else
  assign fetch_err = 1'b0;
  assign load_we   = load_en;
`endif

  // Array write port. The contents are deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (load_we) begin
      mem[ld_idx] <= load_data;
    end
  end

  // Fetch pipeline, one generate block per stage.
  // Stage 0 is the registered array read taken at the acceptance edge, so a
  // load to the same address at that edge is not seen (old word returned).
  // Data and error flags only move with a valid token. The last stage
  // therefore keeps the most recently returned word, which gives the
  // hold-between-completions behaviour of instr_dout for free. Only the
  // valid bits need the reset.
  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    logic              valid_q;
    logic              valid_in;
    logic              err_q;
    logic              err_in;
    logic [DATA_W-1:0] data_q;

    if (gi == 0) begin : g_head
      assign valid_in = accept;
      assign err_in   = fetch_err;

      always_ff @(posedge clock) begin
        if (accept) begin
          data_q <= mem[rd_idx];
        end
      end
    end else begin : g_body
      assign valid_in = g_stage[gi-1].valid_q;
      assign err_in   = g_stage[gi-1].err_q;

      always_ff @(posedge clock) begin
        if (valid_in) begin
          data_q <= g_stage[gi-1].data_q;
        end
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_in;
      end
    end

    always_ff @(posedge clock) begin
      if (valid_in) begin
        err_q <= err_in;
      end
    end
  end

  assign completing = g_stage[LATENCY-1].valid_q;
  assign last_vin   = g_stage[LATENCY-1].valid_in;
  assign last_data  = g_stage[LATENCY-1].data_q;
  assign last_err   = g_stage[LATENCY-1].err_q;

  // Outstanding count. A simultaneous accept and completion cancel out.
  always_comb begin
    count_next = count_reg;
    if (accept && !completing) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!accept && completing) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // The data path itself has no reset. This flag forces instr_dout to zero
  // from reset until the next word lands in the last stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_clr_reg <= 1'b1;
    end else if (last_vin) begin
      out_clr_reg <= 1'b0;
    end
  end

  assign complete_instr = completing;
  assign addr_err       = completing & last_err;
  assign instr_dout     = out_clr_reg ? '0 : (last_err ? TRAP_WORD : last_data);

endmodule
